jtag_ir_param: RTL and testbench
================================

// Module: jtag_ir_param
// PURPOSE
//   Parametrised IEEE 1149.1 TAP instruction register: capture/shift/update path plus opcode decoder.
//   Generalises the fixed 6-instruction IR to any IR width, instruction count and opcode table.
//   Adds unmapped-opcode fallback to BYPASS, status capture, an encoded active-opcode output and an optional scan-length check.
//   Sits between the TAP controller (capture_ir/shift_ir/update_ir strobes) and the data-register mux.
// PARAMETERS
//   IR_WIDTH      4      IR length in bits. Minimum 2.
//   INST_COUNT    6      Number of decoded instructions, i.e. the width of the one-hot output.
//   OPCODES       {4'b0101,4'b0100,4'b0001,4'b0000,4'b0010,4'b1111}
//                        Packed table; entry i is OPCODES[i*IR_WIDTH +: IR_WIDTH].
//   BYPASS_INDEX  0      Table index selected for unmapped opcodes. Its entry must be all ones.
//   RESET_INDEX   3      Table index loaded on reset (IDCODE).
// PORTS
//   tck             in   1                TAP clock. All state updates on posedge.
//   tl_reset        in   1                Test-logic reset. Asynchronous, active-low.
//   tdi             in   1                Serial data in.
//   capture_ir      in   1                Capture-IR state qualifier.
//   shift_ir        in   1                Shift-IR state qualifier.
//   update_ir       in   1                Update-IR state qualifier.
//   capture_status  in   IR_WIDTH-2       Design status loaded into IR bits [W-1:2] on capture.
//   tdo             out  1                Serial out = shift_reg[0] (combinational from the flop).
//   instructions    out  INST_COUNT       One-hot decoded active instruction.
//   ir_active       out  IR_WIDTH         Opcode of the last accepted update.
//   ir_valid_op     out  1                1 = last accepted opcode matched a table entry.
//   scan_err        out  1                Scan-length error (see CONFIGURATION).
// BEHAVIOUR
//   Reset (tl_reset=0, async, any time, including mid-scan):
//     shift_reg={0..0,2'b01}; instructions=1<<RESET_INDEX; ir_active=OPCODES[RESET_INDEX]; ir_valid_op=1; scan_err=0.
//   Shift path, priority capture > shift > hold:
//     capture_ir: shift_reg <= {capture_status, 2'b01}   (1149.1 7.1.1 d/e)
//     shift_ir:   shift_reg <= {tdi, shift_reg[W-1:1]}   (LSB out first)
//   Decode (combinational on shift_reg):
//     Lowest table index whose opcode equals shift_reg wins.
//     No match -> one-hot BYPASS_INDEX, match flag 0.
//   Update: at a posedge with update_ir=1:
//     instructions <= decode; ir_active <= shift_reg (raw, even if unmapped); ir_valid_op <= match flag.
//     No latency beyond that edge; instructions change only on update or reset.
//   Simultaneous update_ir with capture_ir/shift_ir (illegal TAP sequence) is still defined:
//     update uses the pre-edge shift_reg; capture/shift applies in the same edge.
//   Duplicate table entries are legal; the lower index shadows the higher.
// CONFIGURATION
//   Macro IR_SCAN_CHECK_EN.
//   Defined:
//     - Shift counter cleared on capture, +1 per shift_ir edge, saturates at IR_WIDTH+1.
//     - Update accepted only if count==IR_WIDTH. Otherwise instructions/ir_active/ir_valid_op hold and scan_err <= 1.
//     - scan_err is sticky: cleared by the next accepted update or by reset.
//     - Update with no capture since reset counts as 0 shifts -> rejected.
//   Not defined: no counter; every update accepted; scan_err tied 0.
// TESTING
//   1. Release reset -> instructions=6'b001000, ir_active=4'b0001, ir_valid_op=1, tdo=1.
//   2. capture(status=2'b10), 4 shifts with tdi=0 -> tdo sequence 1,0,0,1; then shift_reg=0000.
//   3. capture, shift tdi 0,1,0,0, update -> instructions=6'b000010, ir_active=4'b0010, ir_valid_op=1.
//   4. Shift in 0111 (unmapped), update -> instructions=6'b000001, ir_active=4'b0111, ir_valid_op=0.
//   5. Load 0000, update; pulse tl_reset low mid-scan -> outputs return to IDCODE immediately, no clock needed.
//   6. IR_SCAN_CHECK_EN: capture, 3 shifts, update -> instructions unchanged, scan_err=1;
//      then capture, 4 shifts of 0100, update -> instructions=6'b010000, scan_err=0.

Source files
------------

// File: rtl/jtag_ir_param.sv
`default_nettype none
// ============================================================================
// Module      : jtag_ir_param
// Description : Parametrised IEEE 1149.1 TAP instruction register with
//               capture/shift/update path, table-driven opcode decoder,
//               unmapped-opcode fallback to BYPASS, status capture and an
//               encoded active-opcode output.
//               Optional feature macro: IR_SCAN_CHECK_EN (scan-length check;
//               an update is accepted only after exactly IR_WIDTH shifts).
// Revision    : 1.0 - initial release
// ============================================================================
module jtag_ir_param #(
  parameter int                              IR_WIDTH     = 4,
  parameter int                              INST_COUNT   = 6,
  parameter logic [IR_WIDTH*INST_COUNT-1:0]  OPCODES      = {4'b0101, 4'b0100, 4'b0001,
                                                             4'b0000, 4'b0010, 4'b1111},
  parameter int                              BYPASS_INDEX = 0,
  parameter int                              RESET_INDEX  = 3
) (
  input  logic                  tck,
  input  logic                  tl_reset,
  input  logic                  tdi,
  input  logic                  capture_ir,
  input  logic                  shift_ir,
  input  logic                  update_ir,
  input  logic [IR_WIDTH-3:0]   capture_status,
  output logic                  tdo,
  output logic [INST_COUNT-1:0] instructions,
  output logic [IR_WIDTH-1:0]   ir_active,
  output logic                  ir_valid_op,
  output logic                  scan_err
);

  localparam logic [INST_COUNT-1:0] RESET_ONEHOT = INST_COUNT'(1) << RESET_INDEX;
  localparam logic [IR_WIDTH-1:0]   RESET_OPCODE = OPCODES[RESET_INDEX*IR_WIDTH +: IR_WIDTH];
  localparam logic [IR_WIDTH-1:0]   RESET_SHIFT  = IR_WIDTH'(1);

  logic [IR_WIDTH-1:0]   r_shift;
  logic [INST_COUNT-1:0] w_dec;
  logic                  w_match;
  logic                  w_accept;

  // Capture/shift path; capture wins over shift, otherwise hold.
  always_ff @(posedge tck or negedge tl_reset) begin
    if (!tl_reset) begin
      r_shift <= RESET_SHIFT;
    end else if (capture_ir) begin
      r_shift <= {capture_status, 2'b01};
    end else if (shift_ir) begin
      r_shift <= {tdi, r_shift[IR_WIDTH-1:1]};
    end
  end

  assign tdo = r_shift[0];

  // Table lookup: scan from the top down so the lowest matching index wins.
  always_comb begin
    w_dec               = '0;
    w_dec[BYPASS_INDEX] = 1'b1;
    w_match             = 1'b0;
    for (int i = INST_COUNT - 1; i >= 0; i--) begin
      if (r_shift == OPCODES[i*IR_WIDTH +: IR_WIDTH]) begin
        w_dec    = '0;
        w_dec[i] = 1'b1;
        w_match  = 1'b1;
      end
    end
  end

`ifdef IR_SCAN_CHECK_EN
  localparam int                CNT_W   = $clog2(IR_WIDTH + 2);
  localparam logic [CNT_W-1:0]  CNT_OK  = CNT_W'(IR_WIDTH);
  localparam logic [CNT_W-1:0]  CNT_SAT = CNT_W'(IR_WIDTH + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  // Shift-length counter: cleared on capture, saturating so long scans stay rejected.
  always_ff @(posedge tck or negedge tl_reset) begin
    if (!tl_reset) begin
      r_cnt <= '0;
    end else if (capture_ir) begin
      r_cnt <= '0;
    end else if (shift_ir && (r_cnt != CNT_SAT)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign w_accept = (r_cnt == CNT_OK);

  // Sticky error: set by a rejected update, cleared by an accepted one.
  always_ff @(posedge tck or negedge tl_reset) begin
    if (!tl_reset) begin
      r_err <= 1'b0;
    end else if (update_ir) begin
      r_err <= !w_accept;
    end
  end

  assign scan_err = r_err;
`else
  assign w_accept = 1'b1;
  assign scan_err = 1'b0;
`endif

  // Update stage: latch the decode and raw opcode using the pre-edge shift register.
  always_ff @(posedge tck or negedge tl_reset) begin
    if (!tl_reset) begin
      instructions <= RESET_ONEHOT;
      ir_active    <= RESET_OPCODE;
      ir_valid_op  <= 1'b1;
    end else if (update_ir && w_accept) begin
      instructions <= w_dec;
      ir_active    <= r_shift;
      ir_valid_op  <= w_match;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jtag_ir_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_jtag_ir_param
// Description : Self-checking bench for jtag_ir_param (default parameters).
//               Behavioural IR model compared on every falling edge, plus
//               hand-computed literal checks. Honours IR_SCAN_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jtag_ir_param;

`ifdef IR_SCAN_CHECK_EN
  localparam bit SCAN = 1'b1;
`else
  localparam bit SCAN = 1'b0;
`endif

  // Opcode table, index 0 in the low nibble.
  localparam logic [23:0] TBL = {4'b0101, 4'b0100, 4'b0001, 4'b0000, 4'b0010, 4'b1111};

  logic       tck = 1'b0;
  logic       tl_reset = 1'b0;
  logic       tdi = 1'b0;
  logic       capture_ir = 1'b0;
  logic       shift_ir = 1'b0;
  logic       update_ir = 1'b0;
  logic [1:0] capture_status = 2'b10;
  logic       tdo;
  logic [5:0] instructions;
  logic [3:0] ir_active;
  logic       ir_valid_op;
  logic       scan_err;

  int nvec = 0;
  int nerr = 0;
  bit cmp_en = 1'b0;

  jtag_ir_param dut (
    .tck            (tck),
    .tl_reset       (tl_reset),
    .tdi            (tdi),
    .capture_ir     (capture_ir),
    .shift_ir       (shift_ir),
    .update_ir      (update_ir),
    .capture_status (capture_status),
    .tdo            (tdo),
    .instructions   (instructions),
    .ir_active      (ir_active),
    .ir_valid_op    (ir_valid_op),
    .scan_err       (scan_err)
  );

  always #5 tck = ~tck;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [5:0] model_onehot(input logic [3:0] v);
    for (int i = 0; i < 6; i++)
      if (TBL[i*4 +: 4] == v) return 6'(1 << i);
    return 6'b000001;
  endfunction

  function automatic logic model_mapped(input logic [3:0] v);
    for (int i = 0; i < 6; i++)
      if (TBL[i*4 +: 4] == v) return 1'b1;
    return 1'b0;
  endfunction

  logic [3:0] m_ir;
  logic [5:0] m_inst;
  logic [3:0] m_act;
  logic       m_valid;
  logic       m_err;
  int         m_cnt;

  always @(posedge tck or negedge tl_reset) begin
    if (!tl_reset) begin
      m_ir    <= 4'd1;
      m_inst  <= 6'b001000;
      m_act   <= 4'b0001;
      m_valid <= 1'b1;
      m_err   <= 1'b0;
      m_cnt   <= 0;
    end else begin
      if (update_ir) begin
        if (!SCAN || m_cnt == 4) begin
          m_inst  <= model_onehot(m_ir);
          m_act   <= m_ir;
          m_valid <= model_mapped(m_ir);
          m_err   <= 1'b0;
        end else begin
          m_err   <= 1'b1;
        end
      end
      if (capture_ir) begin
        m_ir  <= 4'(capture_status * 4 + 1);
        m_cnt <= 0;
      end else if (shift_ir) begin
        m_ir  <= 4'((m_ir / 2) + (tdi ? 8 : 0));
        m_cnt <= (m_cnt + 1 > 5) ? 5 : m_cnt + 1;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge tck) begin
    if (tl_reset && cmp_en) begin
      chk("instructions", 32'(instructions), 32'(m_inst));
      chk("ir_active",    32'(ir_active),    32'(m_act));
      chk("ir_valid_op",  32'(ir_valid_op),  32'(m_valid));
      chk("tdo",          32'(tdo),          32'(m_ir[0]));
      chk("scan_err",     32'(scan_err),     32'(SCAN ? m_err : 1'b0));
    end
  end

  // ---------------- stimulus ----------------
  // Apply one cycle of strobes; returns just after the following falling edge.
  task automatic step(input logic c, input logic s, input logic u, input logic d);
    capture_ir = c;
    shift_ir   = s;
    update_ir  = u;
    tdi        = d;
    @(negedge tck);
    #1;
  endtask

  task automatic scan(input logic [7:0] val, input int n);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, val[i]);
  endtask

  task automatic upd();
    step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic chk_out(input string tag, input logic [5:0] inst, input logic [3:0] act,
                         input logic vld);
    chk({tag, ".instructions"}, 32'(instructions), 32'(inst));
    chk({tag, ".ir_active"},    32'(ir_active),    32'(act));
    chk({tag, ".ir_valid_op"},  32'(ir_valid_op),  32'(vld));
  endtask

  logic [3:0] seq;

  initial begin
    #12 tl_reset = 1'b1;
    @(negedge tck);
    #1;
    cmp_en = 1'b1;

    // 1: reset state
    chk_out("reset", 6'b001000, 4'b0001, 1'b1);
    chk("reset.tdo", 32'(tdo), 32'd1);
    chk("reset.scan_err", 32'(scan_err), 32'd0);

    // 2: status capture and LSB-first shift-out
    capture_status = 2'b10;
    seq = 4'b1001;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("tdo_seq0", 32'(tdo), 32'(seq[0]));
    for (int k = 1; k < 4; k++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      chk("tdo_seq", 32'(tdo), 32'(seq[k]));
    end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("shift_reg_zero.tdo", 32'(tdo), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // 3: mapped opcode 0010
    scan(8'b0010, 4);
    upd();
    chk_out("op0010", 6'b000010, 4'b0010, 1'b1);
    chk("op0010.scan_err", 32'(scan_err), 32'd0);

    // 4: unmapped opcode falls back to BYPASS
    scan(8'b0111, 4);
    upd();
    chk_out("op0111", 6'b000001, 4'b0111, 1'b0);

    // 5: load 0000, then asynchronous reset mid-scan
    scan(8'b0000, 4);
    upd();
    chk_out("op0000", 6'b000100, 4'b0000, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    #1 tl_reset = 1'b0;
    #1;
    chk_out("async_rst", 6'b001000, 4'b0001, 1'b1);
    chk("async_rst.tdo", 32'(tdo), 32'd1);
    chk("async_rst.scan_err", 32'(scan_err), 32'd0);
    #1 tl_reset = 1'b1;
    @(negedge tck);
    #1;

    // 6a: short scan (3 shifts)
    scan(8'b0010, 3);
    upd();
    if (SCAN) begin
      chk_out("short_scan", 6'b001000, 4'b0001, 1'b1);
      chk("short_scan.scan_err", 32'(scan_err), 32'd1);
    end else begin
      chk("short_scan.scan_err", 32'(scan_err), 32'd0);
    end

    // 6b: correct-length scan of 0100 clears the error
    scan(8'b0100, 4);
    upd();
    chk_out("op0100", 6'b010000, 4'b0100, 1'b1);
    chk("op0100.scan_err", 32'(scan_err), 32'd0);

    // Simultaneous update+capture, then update+shift (illegal but defined)
    capture_status = 2'b01;
    scan(8'b0010, 4);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk_out("upd_cap", 6'b000010, 4'b0010, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    if (SCAN) begin
      chk_out("upd_shift", 6'b000010, 4'b0010, 1'b1);
      chk("upd_shift.scan_err", 32'(scan_err), 32'd1);
    end else begin
      chk_out("upd_shift", 6'b100000, 4'b0101, 1'b1);
    end

    // Over-long scan (6 shifts) saturates the counter
    scan(8'b0001_0000, 6);
    upd();
    if (SCAN) chk("long_scan.scan_err", 32'(scan_err), 32'd1);
    else      chk_out("long_scan", 6'b010000, 4'b0100, 1'b1);

    // Recover with IDCODE
    scan(8'b0001, 4);
    upd();
    chk_out("idcode", 6'b001000, 4'b0001, 1'b1);
    chk("idcode.scan_err", 32'(scan_err), 32'd0);

    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
